// File: rtl/oled_seq.sv
// SSD1306 128x32 power/init sequencer feeding an SPI byte transmitter.
// Define OLED_SEQ_CLEAR_EN to blank GDDRAM (512 zero data bytes) before READY.
module oled_seq #(
  parameter int unsigned T_VDD_CYC    = 100000,
  parameter int unsigned T_RES_CYC    = 100,
  parameter int unsigned T_VBAT_CYC   = 10000000,
  parameter int unsigned SPI_BYTE_CYC = 100
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       power_on_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  input  logic       byte_dc_i,
  output logic       byte_ready_o,
  output logic       powered_o,
  output logic       busy_o,
  output logic       spi_start_o,
  output logic [7:0] spi_data_o,
  input  logic       spi_ready_i,
  output logic       dc_o,
  output logic       res_no,
  output logic       vdd_no,
  output logic       vbat_no
);

  localparam logic [23:0] VDD_LD  = 24'(T_VDD_CYC - 1);
  localparam logic [23:0] RES_LD  = 24'(T_RES_CYC - 1);
  localparam logic [23:0] VBAT_LD = 24'(T_VBAT_CYC - 1);
  localparam logic [23:0] BYTE_LD = 24'(SPI_BYTE_CYC - 1);

`ifdef OLED_SEQ_CLEAR_EN
  localparam logic [3:0] LAST_B = 4'd13;
`else
  localparam logic [3:0] LAST_B = 4'd11;
`endif

  typedef enum logic [3:0] {
    OFF, VDD_WAIT, CMD_OFF, RES_LO, RES_HI,
    INIT_A, VBAT_WAIT, INIT_B, CLEAR, READY,
    XFER, DOWN_CMD, DOWN_WAIT
  } state_e;

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_TAIL
  } bstate_e;

  function automatic logic [7:0] rom(input logic [3:0] a);
    case (a)
      4'd0:    rom = 8'hAE;
      4'd1:    rom = 8'h8D;
      4'd2:    rom = 8'h14;
      4'd3:    rom = 8'hD9;
      4'd4:    rom = 8'hF1;
      4'd5:    rom = 8'h81;
      4'd6:    rom = 8'h0F;
      4'd7:    rom = 8'hA1;
      4'd8:    rom = 8'hC8;
      4'd9:    rom = 8'hDA;
      4'd10:   rom = 8'h20;
      4'd11:   rom = 8'hAF;
      4'd12:   rom = 8'h20;
      default: rom = 8'h00;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_q, hold_d;
  logic        hdc_q, hdc_d;
  logic        vdd_d, vbat_d, res_d, pwr_d;
  logic        req, req_dc, bdone, zero;
  logic [7:0]  req_data;

`ifdef OLED_SEQ_CLEAR_EN
  logic [9:0]  clr_q, clr_d;
`endif

  bstate_e     bst_q, bst_d;
  logic [23:0] bcnt_q, bcnt_d;
  logic        start_d, dc_d;
  logic [7:0]  data_d;

  assign zero         = (cnt_q == 24'd0);
  assign bdone        = (bst_q == B_TAIL) && spi_ready_i;
  assign byte_ready_o = (state_q == READY) && power_on_i;
  assign busy_o       = (state_q != OFF) && (state_q != READY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      hdc_q     <= 1'b0;
      vdd_no    <= 1'b1;
      vbat_no   <= 1'b1;
      res_no    <= 1'b1;
      powered_o <= 1'b0;
`ifdef OLED_SEQ_CLEAR_EN
      clr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      hdc_q     <= hdc_d;
      vdd_no    <= vdd_d;
      vbat_no   <= vbat_d;
      res_no    <= res_d;
      powered_o <= pwr_d;
`ifdef OLED_SEQ_CLEAR_EN
      clr_q     <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    hdc_d    = hdc_q;
    vdd_d    = vdd_no;
    vbat_d   = vbat_no;
    res_d    = res_no;
    pwr_d    = powered_o;
    req      = 1'b0;
    req_data = rom(ptr_q);
    req_dc   = 1'b0;
`ifdef OLED_SEQ_CLEAR_EN
    clr_d    = clr_q;
`endif
    unique case (state_q)
      OFF: begin
        if (power_on_i) begin
          vdd_d   = 1'b0;
          cnt_d   = VDD_LD;
          state_d = VDD_WAIT;
        end
      end
      VDD_WAIT: begin
        if (zero) begin
          ptr_d   = 4'd0;
          state_d = CMD_OFF;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      CMD_OFF: begin
        req = 1'b1;
        if (bdone) begin
          res_d   = 1'b0;
          cnt_d   = RES_LD;
          ptr_d   = 4'd1;
          state_d = RES_LO;
        end
      end
      RES_LO: begin
        if (zero) begin
          res_d   = 1'b1;
          cnt_d   = RES_LD;
          state_d = RES_HI;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      RES_HI: begin
        if (zero) state_d = INIT_A;
        else      cnt_d   = cnt_q - 24'd1;
      end
      INIT_A: begin
        req = 1'b1;
        if (bdone) begin
          ptr_d = ptr_q + 4'd1;
          if (ptr_q == 4'd4) begin
            vbat_d  = 1'b0;
            cnt_d   = VBAT_LD;
            state_d = VBAT_WAIT;
          end
        end
      end
      VBAT_WAIT: begin
        if (zero) state_d = INIT_B;
        else      cnt_d   = cnt_q - 24'd1;
      end
      INIT_B: begin
        req = 1'b1;
        if (bdone) begin
          ptr_d = ptr_q + 4'd1;
          if (ptr_q == LAST_B) begin
`ifdef OLED_SEQ_CLEAR_EN
            clr_d   = '0;
            state_d = CLEAR;
`else
            pwr_d   = 1'b1;
            state_d = READY;
`endif
          end
        end
      end
`ifdef OLED_SEQ_CLEAR_EN
      CLEAR: begin
        req      = 1'b1;
        req_data = 8'h00;
        req_dc   = 1'b1;
        if (bdone) begin
          clr_d = clr_q + 10'd1;
          if (clr_q == 10'd511) begin
            pwr_d   = 1'b1;
            state_d = READY;
          end
        end
      end
`endif
      READY: begin
        if (!power_on_i) begin
          pwr_d   = 1'b0;
          state_d = DOWN_CMD;
        end else begin
          // accept cycle feeds the engine directly so start rises next cycle
          req      = byte_valid_i;
          req_data = byte_data_i;
          req_dc   = byte_dc_i;
          if (byte_valid_i) begin
            hold_d  = byte_data_i;
            hdc_d   = byte_dc_i;
            state_d = XFER;
          end
        end
      end
      XFER: begin
        req      = 1'b1;
        req_data = hold_q;
        req_dc   = hdc_q;
        if (bdone) state_d = READY;
      end
      DOWN_CMD: begin
        req      = 1'b1;
        req_data = 8'hAE;
        if (bdone) begin
          vbat_d  = 1'b1;
          cnt_d   = VBAT_LD;
          state_d = DOWN_WAIT;
        end
      end
      DOWN_WAIT: begin
        if (zero) begin
          vdd_d   = 1'b1;
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bst_q       <= B_IDLE;
      bcnt_q      <= '0;
      spi_start_o <= 1'b0;
      spi_data_o  <= '0;
      dc_o        <= 1'b0;
    end else begin
      bst_q       <= bst_d;
      bcnt_q      <= bcnt_d;
      spi_start_o <= start_d;
      spi_data_o  <= data_d;
      dc_o        <= dc_d;
    end
  end

  always_comb begin
    bst_d   = bst_q;
    bcnt_d  = bcnt_q;
    start_d = spi_start_o;
    data_d  = spi_data_o;
    dc_d    = dc_o;
    unique case (bst_q)
      B_IDLE: begin
        if (req && spi_ready_i) begin
          start_d = 1'b1;
          data_d  = req_data;
          dc_d    = req_dc;
          bcnt_d  = BYTE_LD;
          bst_d   = B_START;
        end
      end
      B_START: begin
        if (bcnt_q == 24'd0) begin
          start_d = 1'b0;
          bst_d   = B_TAIL;
        end else begin
          bcnt_d = bcnt_q - 24'd1;
        end
      end
      B_TAIL: begin
        if (spi_ready_i) bst_d = B_IDLE;
      end
      default: bst_d = B_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_seq.sv
// Scoreboard bench for oled_seq with a behavioural SPI transmitter.
// Honours OLED_SEQ_CLEAR_EN the same way as the design.
module tb_oled_seq;

`ifdef OLED_SEQ_CLEAR_EN
  localparam int SPI_BYTE = 20;
`else
  localparam int SPI_BYTE = 100;
`endif
  localparam int T_VDD  = 20;
  localparam int T_RES  = 5;
  localparam int T_VBAT = 50;
  localparam int SH_CYC = SPI_BYTE - 5;
  localparam int LIM    = 60000;

  logic       clk;
  logic       rst_ni;
  logic       power_on_i;
  logic       byte_valid_i;
  logic [7:0] byte_data_i;
  logic       byte_dc_i;
  logic       byte_ready_o;
  logic       powered_o;
  logic       busy_o;
  logic       spi_start_o;
  logic [7:0] spi_data_o;
  logic       spi_ready_i;
  logic       dc_o;
  logic       res_no;
  logic       vdd_no;
  logic       vbat_no;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [9:0] got_q[$];

  oled_seq #(
    .T_VDD_CYC    (T_VDD),
    .T_RES_CYC    (T_RES),
    .T_VBAT_CYC   (T_VBAT),
    .SPI_BYTE_CYC (SPI_BYTE)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .power_on_i   (power_on_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_dc_i    (byte_dc_i),
    .byte_ready_o (byte_ready_o),
    .powered_o    (powered_o),
    .busy_o       (busy_o),
    .spi_start_o  (spi_start_o),
    .spi_data_o   (spi_data_o),
    .spi_ready_i  (spi_ready_i),
    .dc_o         (dc_o),
    .res_no       (res_no),
    .vdd_no       (vdd_no),
    .vbat_no      (vbat_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI transmitter: frame latched on start, ready back after
  // the shift time once start has been released.
  logic       act;
  logic       stab;
  logic [8:0] cur;
  int         sh;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      spi_ready_i <= 1'b1;
      act         <= 1'b0;
      stab        <= 1'b1;
      cur         <= '0;
      sh          <= 0;
    end else if (!act) begin
      if (spi_start_o && spi_ready_i) begin
        act         <= 1'b1;
        spi_ready_i <= 1'b0;
        cur         <= {dc_o, spi_data_o};
        stab        <= 1'b1;
        sh          <= SH_CYC;
      end
    end else begin
      if ({dc_o, spi_data_o} != cur) stab <= 1'b0;
      if (sh > 0) begin
        sh <= sh - 1;
      end else if (!spi_start_o) begin
        act         <= 1'b0;
        spi_ready_i <= 1'b1;
        got_q.push_back({stab && ({dc_o, spi_data_o} == cur), cur});
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got timeout exp event", nm);
  endtask

  // monitor: pops one expectation per completed SPI frame
  initial begin
    logic [9:0] g;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_extra got %h exp none", g[8:0]);
        end else begin
          e = exp_q.pop_front();
          chk("frame", {23'd0, g[8:0]}, {23'd0, e});
          chk("frame_stable", {31'd0, g[9]}, 32'd1);
        end
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       sig = vdd_no;
      1:       sig = vbat_no;
      2:       sig = res_no;
      3:       sig = powered_o;
      4:       sig = busy_o;
      5:       sig = spi_start_o;
      default: sig = byte_ready_o;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input logic val,
                           input string nm, output int n);
    n = 0;
    for (int i = 0; i < LIM; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (sig(sel) === val) return;
    end
    note_fail(nm);
  endtask

  task automatic push_init();
    logic [7:0] lst[12];
    lst = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
            8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    foreach (lst[i]) exp_q.push_back({1'b0, lst[i]});
`ifdef OLED_SEQ_CLEAR_EN
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, 8'h00});
    for (int i = 0; i < 512; i++) exp_q.push_back({1'b1, 8'h00});
`endif
  endtask

  task automatic send_byte(input logic [7:0] d, input logic dc);
    int n;
    logic bad;
    wait_cond(6, 1'b1, "wait_ready", n);
    byte_valid_i = 1'b1;
    byte_data_i  = d;
    byte_dc_i    = dc;
    exp_q.push_back({dc, d});
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    chk("start_lat", {31'd0, spi_start_o}, 32'd1);
    chk("rdy_after_acc", {31'd0, byte_ready_o}, 32'd0);
    bad = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < LIM) begin
      if (byte_ready_o !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= LIM) note_fail("xfer_done");
    chk("rdy_low_xfer", {31'd0, bad}, 32'd0);
  endtask

  initial begin
    int n;
    logic seen, ph;
    rst_ni       = 1'b0;
    power_on_i   = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    byte_dc_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", {vdd_no, vbat_no, res_no, dc_o, spi_start_o,
         spi_data_o, byte_ready_o, powered_o, busy_o}, 32'hE000);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_off", {29'd0, vdd_no, busy_o, byte_ready_o}, 32'h4);

    // power-up
    push_init();
    power_on_i = 1'b1;
    @(posedge clk);
    #1;
    chk("vdd_fall", {31'd0, vdd_no}, 32'd0);
    wait_cond(5, 1'b1, "first_start", n);
    chk("vdd_to_start", n, T_VDD + 1);
    wait_cond(1, 1'b0, "vbat_on", n);
    wait_cond(5, 1'b1, "initb_start", n);
    chk("vbat_to_start", n, T_VBAT + 1);
    wait_cond(3, 1'b1, "powered", n);
    chk("busy_ready", {31'd0, busy_o}, 32'd0);
    chk("init_frames_left", exp_q.size(), 0);

    // client bytes
    send_byte(8'h5A, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b1);
    chk("xfer_frames_left", exp_q.size(), 0);

    // power-down
    power_on_i = 1'b0;
    exp_q.push_back({1'b0, 8'hAE});
    @(posedge clk);
    #1;
    chk("pwr_drop", {31'd0, powered_o}, 32'd0);
    wait_cond(1, 1'b1, "vbat_off", n);
    wait_cond(0, 1'b1, "vdd_off", n);
    chk("vbat_to_vdd", n, T_VBAT);
    chk("down_idle", {30'd0, busy_o, powered_o}, 32'd0);
    chk("down_frames_left", exp_q.size(), 0);

    // power_on drops mid-init while a client byte waits
    push_init();
    exp_q.push_back({1'b0, 8'hAE});
    power_on_i   = 1'b1;
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h33;
    byte_dc_i    = 1'b1;
    seen = 1'b0;
    ph   = 1'b0;
    n    = 0;
    while (n < LIM) begin
      @(posedge clk);
      #1;
      n++;
      if (byte_ready_o !== 1'b0) seen = 1'b1;
      if (!ph && vbat_no === 1'b0) begin
        power_on_i = 1'b0;
        ph = 1'b1;
      end else if (ph && vdd_no === 1'b1) begin
        break;
      end
    end
    if (n >= LIM) note_fail("drop_seq");
    byte_valid_i = 1'b0;
    chk("drop_no_accept", {31'd0, seen}, 32'd0);
    chk("drop_idle", {31'd0, busy_o}, 32'd0);
    repeat (2) @(posedge clk);
    chk("drop_frames_left", exp_q.size(), 0);

    // reset during INIT_A
    exp_q.push_back({1'b0, 8'hAE});
    power_on_i = 1'b1;
    wait_cond(2, 1'b0, "res_lo", n);
    wait_cond(2, 1'b1, "res_hi", n);
    wait_cond(5, 1'b1, "inita_start", n);
    rst_ni = 1'b0;
    #1;
    chk("async_reset", {vdd_no, vbat_no, res_no, dc_o, spi_start_o,
         spi_data_o, byte_ready_o, powered_o, busy_o}, 32'hE000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", {29'd0, vdd_no, spi_start_o, busy_o}, 32'h4);
    power_on_i = 1'b0;
    rst_ni     = 1'b1;
    repeat (200) @(posedge clk);
    chk("reset_frames_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_seq.md
# oled_seq

Power and command sequencer for the SSD1306-based 128x32 OLED, sitting directly upstream of the SPI byte transmitter. Drives the panel supply/reset/D-C pins through the datasheet power-up and power-down order, pushes the fixed init command list, then forwards client bytes (command or data) one at a time into the SPI transmitter's start/data/ready handshake.

## Interface
- T_VDD_CYC, 100000: cycles after VDD on before first command (1 ms @ 100 MHz)
- T_RES_CYC, 100: cycles RES held low, and again after release
- T_VBAT_CYC, 10000000: cycles after VBAT on/off (100 ms)
- SPI_BYTE_CYC, 100: cycles spi_start_o held high per byte; must exceed SPI transmitter byte time (~95 cycles)
- Delay counter 24 bits; all delay parameters < 2^24.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- power_on_i  in  1  level: 1 = panel on requested, 0 = off requested
- byte_valid_i  in  1  client byte available
- byte_data_i  in  8  client byte
- byte_dc_i  in  1  0 = command, 1 = display data
- byte_ready_o  out  1  byte accepted this cycle when valid&ready
- powered_o  out  1  init complete, streaming allowed
- busy_o  out  1  any sequence or byte transfer in progress
- spi_start_o  out  1  to SPI transmitter send_start
- spi_data_o  out  8  to SPI transmitter send_data
- spi_ready_i  in  1  from SPI transmitter send_ready
- dc_o, res_no, vdd_no, vbat_no  out  1 each  panel pins (res/vdd/vbat active-low)

## Operation
- Reset values: vdd_no=1, vbat_no=1, res_no=1, dc_o=0, spi_start_o=0, spi_data_o=0, byte_ready_o=0, powered_o=0, busy_o=0; state OFF.
- States: OFF, VDD_WAIT, CMD_OFF, RES_LO, RES_HI, INIT_A, VBAT_WAIT, INIT_B, CLEAR (macro only), READY, XFER, DOWN_CMD, DOWN_WAIT.
- OFF -> VDD_WAIT on power_on_i=1: vdd_no<=0, wait T_VDD_CYC.
- CMD_OFF: send 0xAE. RES_LO: res_no=0 for T_RES_CYC. RES_HI: res_no=1, wait T_RES_CYC.
- INIT_A: send 0x8D,0x14,0xD9,0xF1. VBAT_WAIT: vbat_no<=0, wait T_VBAT_CYC.
- INIT_B: send 0x81,0x0F,0xA1,0xC8,0xDA,0x20,0xAF. Then READY (powered_o=1).
- All sequencer bytes have dc_o=0; list held in a constant ROM indexed by a 4-bit pointer.
- READY: byte_ready_o = power_on_i & ~XFER; on valid&ready latch data/dc -> XFER, return to READY after byte completes.
- READY with power_on_i=0 -> DOWN_CMD: powered_o<=0, send 0xAE; DOWN_WAIT: vbat_no<=1, wait T_VBAT_CYC, then vdd_no<=1 -> OFF.
- power_on_i sampled only in OFF and READY; a drop during power-up completes init first, then powers down immediately. A rise during power-down completes to OFF, then restarts.
- Byte send sub-sequence (every byte): wait spi_ready_i=1; set spi_data_o, dc_o; assert spi_start_o for exactly SPI_BYTE_CYC cycles; deassert; wait spi_ready_i=1 again; byte done.
- spi_data_o and dc_o stable from start rise until byte done.
- busy_o=1 in every state except OFF and READY.

## Timing
- power_on_i rise to vdd_no fall: 1 cycle. vdd_no fall to first spi_start_o rise: T_VDD_CYC+1.
- byte_valid_i&byte_ready_o to spi_start_o rise: 1 cycle if spi_ready_i=1. byte_ready_o low from accept until byte done.
- Reset mid-operation: all outputs to reset values asynchronously; panel rails drop; no power-down ordering.
- Delay counters reload on state entry; count T-1 down to 0, exit on 0.

## Configuration
- OLED_SEQ_CLEAR_EN defined: after 0xAF, send 0x20,0x00 (horizontal addressing, dc=0) then 512 bytes 0x00 with dc_o=1 (10-bit counter) before READY.
- Undefined: INIT_B goes straight to READY; GDDRAM content undefined.

## Test plan
- Params T_VDD=20, T_RES=5, T_VBAT=50, SPI_BYTE=100, real SPI transmitter attached; power_on_i=1 -> vdd_no low, then SPI bytes AE,8D,14,D9,F1, vbat_no low 50 cycles, then 81,0F,A1,C8,DA,20,AF, powered_o=1.
- Ready state, byte 0x5A dc=1 -> one SPI frame 0x5A with dc_o=1 throughout; byte_ready_o low until done.
- Back-to-back bytes 0x00 dc=0, 0xFF dc=1 -> two frames, dc_o changes only between frames.
- power_on_i=0 in READY -> AE sent, vbat_no high, 50 cycles later vdd_no high, busy_o=0.
- power_on_i drops during VBAT_WAIT -> full init then immediate power-down; no client byte accepted.
- rst_ni low during INIT_A -> all outputs reset values same cycle; OLED_SEQ_CLEAR_EN build: 512 zero data frames after AF.
